// File: rtl/ex_shift_stage.sv
// ex_shift_stage: execute-stage slot for RV32I shift instructions.
//
// Takes decoded shift instructions from ID over valid/ready. Drives operands to an
// external combinational shifter (sh_A/sh_B/sh_op) and samples its result in the
// accept cycle. Captured results go into a 2-entry buffer (main + skid) that feeds
// WB over valid/ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       ID handshake; in_ready is registered (= !skid_valid)
//   in_instr                raw instruction word, decoded combinationally
//   in_rs1/in_rs2/in_rd     operand values and destination index
//   sh_A/sh_B/sh_op         shifter operands; op 00 SLL, 01 SRL, 11 SRA
//   sh_result               shifter result, combinational from sh_A/sh_B/sh_op
//   out_valid/out_ready     WB handshake
//   out_rd/out_wdata        destination index and result (0 for illegal)
//   out_we/out_illegal      write enable (legal and rd != 0), illegal flag
//   perf_shift_cnt          retired legal shift count (only with SHIFT_PERF_CNT_EN)
//
// Optional feature macro: SHIFT_PERF_CNT_EN adds perf_shift_cnt and its counter.

module ex_shift_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [4:0]            in_rd,
  output logic [DATA_WIDTH-1:0] sh_A,
  output logic [DATA_WIDTH-1:0] sh_B,
  output logic [1:0]            sh_op,
  input  logic [DATA_WIDTH-1:0] sh_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic                  out_we,
  output logic                  out_illegal
`ifdef SHIFT_PERF_CNT_EN
  ,
  output logic [31:0]           perf_shift_cnt
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRX     = 3'b101;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ARITH   = 7'b0100000;
  localparam logic [1:0] OP_SLL     = 2'b00;
  localparam logic [1:0] OP_SRL     = 2'b01;
  localparam logic [1:0] OP_SRA     = 2'b11;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_reg;
  logic       w_is_imm;
  logic       w_legal;
  logic [1:0] w_op;
  logic       w_unused_instr;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  // For immediate forms this is instr[31:25], which must match exactly, so a set
  // bit 25 (a 6-bit RV64 shamt) falls out as illegal.
  assign w_funct7 = in_instr[31:25];
  assign w_is_reg = (w_opcode == OPC_OP);
  assign w_is_imm = (w_opcode == OPC_OP_IMM);

  // Register-index fields are irrelevant here; operand values arrive pre-read.
  assign w_unused_instr = ^{in_instr[19:15], in_instr[11:7]};

  always_comb begin
    w_legal = 1'b0;
    w_op    = OP_SLL;
    if (w_is_reg || w_is_imm) begin
      if (w_funct3 == F3_SLL && w_funct7 == F7_BASE) begin
        w_legal = 1'b1;
        w_op    = OP_SLL;
      end else if (w_funct3 == F3_SRX && w_funct7 == F7_BASE) begin
        w_legal = 1'b1;
        w_op    = OP_SRL;
      end else if (w_funct3 == F3_SRX && w_funct7 == F7_ARITH) begin
        w_legal = 1'b1;
        w_op    = OP_SRA;
      end
    end
  end

  always_comb begin
    sh_A = in_rs1;
    if (!w_legal) begin
      sh_B = '0;
    end else if (w_is_reg) begin
      sh_B = in_rs2;
    end else begin
      sh_B = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};
    end
    sh_op = w_legal ? w_op : OP_SLL;
  end

  // ---------------------------------------------------------------------------
  // Entry capture and 2-entry output buffer
  // ---------------------------------------------------------------------------
  logic                  r_main_valid;
  logic [4:0]            r_main_rd;
  logic [DATA_WIDTH-1:0] r_main_wdata;
  logic                  r_main_we;
  logic                  r_main_ill;
  logic                  r_skid_valid;
  logic [4:0]            r_skid_rd;
  logic [DATA_WIDTH-1:0] r_skid_wdata;
  logic                  r_skid_we;
  logic                  r_skid_ill;

  logic                  w_fire_in;
  logic                  w_fire_out;
  logic [DATA_WIDTH-1:0] w_ent_wdata;
  logic                  w_ent_we;
  logic                  w_ent_ill;

  // Registered ready: only a full skid can block, so no path from out_ready.
  assign in_ready   = !r_skid_valid;
  assign w_fire_in  = in_valid & in_ready;
  assign w_fire_out = r_main_valid & out_ready;

  assign w_ent_wdata = w_legal ? sh_result : '0;
  assign w_ent_we    = w_legal & (in_rd != 5'd0);
  assign w_ent_ill   = !w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_rd    <= '0;
      r_main_wdata <= '0;
      r_main_we    <= 1'b0;
      r_main_ill   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_rd    <= '0;
      r_skid_wdata <= '0;
      r_skid_we    <= 1'b0;
      r_skid_ill   <= 1'b0;
    end else if (w_fire_out) begin
      if (r_skid_valid) begin
        // Skid holds the older entry; promote it. in_ready was low, so no accept.
        r_main_rd    <= r_skid_rd;
        r_main_wdata <= r_skid_wdata;
        r_main_we    <= r_skid_we;
        r_main_ill   <= r_skid_ill;
        r_skid_valid <= 1'b0;
      end else if (w_fire_in) begin
        r_main_rd    <= in_rd;
        r_main_wdata <= w_ent_wdata;
        r_main_we    <= w_ent_we;
        r_main_ill   <= w_ent_ill;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_fire_in) begin
      if (!r_main_valid) begin
        r_main_valid <= 1'b1;
        r_main_rd    <= in_rd;
        r_main_wdata <= w_ent_wdata;
        r_main_we    <= w_ent_we;
        r_main_ill   <= w_ent_ill;
      end else begin
        // Main is stalled; park the new entry so main stays stable.
        r_skid_valid <= 1'b1;
        r_skid_rd    <= in_rd;
        r_skid_wdata <= w_ent_wdata;
        r_skid_we    <= w_ent_we;
        r_skid_ill   <= w_ent_ill;
      end
    end
  end

  assign out_valid   = r_main_valid;
  assign out_rd      = r_main_rd;
  assign out_wdata   = r_main_wdata;
  assign out_we      = r_main_we;
  assign out_illegal = r_main_ill;

`ifdef SHIFT_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // Counts retired legal shifts; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt <= '0;
    end else if (w_fire_out && !r_main_ill) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_shift_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_ex_shift_stage.sv
module tb_ex_shift_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] sh_A;
  logic [31:0] sh_B;
  logic [1:0]  sh_op;
  logic [31:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_wdata;
  logic        out_we;
  logic        out_illegal;
`ifdef SHIFT_PERF_CNT_EN
  logic [31:0] perf_shift_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        we;
    logic        ill;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_perf = 32'd0;

  always #5 clk = ~clk;

  ex_shift_stage #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .sh_A       (sh_A),
    .sh_B       (sh_B),
    .sh_op      (sh_op),
    .sh_result  (sh_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_wdata  (out_wdata),
    .out_we     (out_we),
    .out_illegal(out_illegal)
`ifdef SHIFT_PERF_CNT_EN
    ,
    .perf_shift_cnt(perf_shift_cnt)
`endif
  );

  // Stand-in for the external combinational shifter.
  always_comb begin
    case (sh_op)
      2'b00:   sh_result = sh_A << sh_B[4:0];
      2'b01:   sh_result = sh_A >> sh_B[4:0];
      2'b11:   sh_result = 32'($signed(sh_A) >>> sh_B[4:0]);
      default: sh_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what WB should see for an instruction, straight from the ISA rules.
  function automatic ent_t model(input logic [31:0] ins, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [4:0] rd);
    ent_t        e;
    int          kind;
    int unsigned sh;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    sh   = (opc == 7'h33) ? int'(rs2[4:0]) : int'(ins[24:20]);
    kind = -1;
    if (opc == 7'h33 || opc == 7'h13) begin
      if (f3 == 3'd1 && f7 == 7'h00)      kind = 0;
      else if (f3 == 3'd5 && f7 == 7'h00) kind = 1;
      else if (f3 == 3'd5 && f7 == 7'h20) kind = 2;
    end
    e.rd  = rd;
    e.ill = (kind < 0);
    case (kind)
      0:       e.wdata = rs1 << sh;
      1:       e.wdata = rs1 >> sh;
      2:       e.wdata = 32'($signed(rs1) >>> sh);
      default: e.wdata = 32'd0;
    endcase
    e.we = !e.ill && (rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    logic [31:0] r;
    a = 5'($urandom);
    b = 5'($urandom);
    c = 5'($urandom);
    case ($urandom_range(0, 9))
      0:       r = {7'h00, a, b, 3'b001, c, 7'h33};
      1:       r = {7'h00, a, b, 3'b101, c, 7'h33};
      2:       r = {7'h20, a, b, 3'b101, c, 7'h33};
      3:       r = {7'h00, a, b, 3'b001, c, 7'h13};
      4:       r = {7'h00, a, b, 3'b101, c, 7'h13};
      5:       r = {7'h20, a, b, 3'b101, c, 7'h13};
      6:       r = {7'h01, a, b, 3'b101, c, 7'h13};
      7:       r = {7'h00, a, b, 3'b000, c, 7'h33};
      8:       r = {7'h20, a, b, 3'b001, c, 7'h13};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Called at a falling edge with this cycle's inputs applied: checks the DUT
  // against the model, then advances the model across the next rising edge.
  task automatic tick(output bit fin);
    bit   fout;
    ent_t e;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      e = q[0];
      chk("out_rd", out_rd, e.rd);
      chk("out_wdata", out_wdata, e.wdata);
      chk("out_we", out_we, e.we);
      chk("out_illegal", out_illegal, e.ill);
    end
`ifdef SHIFT_PERF_CNT_EN
    chk("perf_shift_cnt", perf_shift_cnt, exp_perf);
`endif
    fout = (q.size() != 0) && out_ready;
    fin  = in_valid && (q.size() < 2);
    if (fout) begin
      if (!q[0].ill) exp_perf = exp_perf + 32'd1;
      void'(q.pop_front());
    end
    if (fin) q.push_back(model(in_instr, in_rs1, in_rs2, in_rd));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [4:0] rd);
    in_valid = 1'b1;
    in_instr = ins;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
  endtask

  initial begin
    bit          fin;
    int          idx;
    logic [31:0] b2b_ins[4];
    logic [31:0] b2b_rs1[4];
    logic [31:0] b2b_rs2[4];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_rs1    = 32'd0;
    in_rs2    = 32'd0;
    in_rd     = 5'd0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_rd", out_rd, 5'd0);
    chk("rst_out_wdata", out_wdata, 32'd0);
    chk("rst_out_we", out_we, 1'b0);
    chk("rst_out_illegal", out_illegal, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick(fin);

    // SRA x5, rs1=0x80000010, rs2=0x24 (shamt 4)
    out_ready = 1'b1;
    drive({7'h20, 5'd2, 5'd1, 3'b101, 5'd5, 7'h33}, 32'h8000_0010, 32'h0000_0024, 5'd5);
    tick(fin);
    chk("sra_accept", fin, 1'b1);
    in_valid = 1'b0;
    chk("sra_valid", out_valid, 1'b1);
    chk("sra_wdata", out_wdata, 32'hF800_0001);
    chk("sra_we", out_we, 1'b1);
    chk("sra_illegal", out_illegal, 1'b0);
    tick(fin);

    // SLLI x0, shamt 31
    drive({7'h00, 5'd31, 5'd1, 3'b001, 5'd0, 7'h13}, 32'h0000_0001, 32'h1234_5678, 5'd0);
    tick(fin);
    in_valid = 1'b0;
    chk("slli_wdata", out_wdata, 32'h8000_0000);
    chk("slli_we", out_we, 1'b0);
    tick(fin);

    // SRLI with instr[25]=1 is illegal
    drive({7'h01, 5'd3, 5'd1, 3'b101, 5'd7, 7'h13}, 32'hFFFF_FFFF, 32'd0, 5'd7);
    tick(fin);
    in_valid = 1'b0;
    chk("srli25_illegal", out_illegal, 1'b1);
    chk("srli25_wdata", out_wdata, 32'd0);
    chk("srli25_we", out_we, 1'b0);
    tick(fin);

    // Back-to-back four with WB stalled: two captured, then in_ready drops
    b2b_ins[0] = {7'h00, 5'd2, 5'd1, 3'b001, 5'd0, 7'h33};
    b2b_ins[1] = {7'h00, 5'd2, 5'd1, 3'b101, 5'd0, 7'h33};
    b2b_ins[2] = {7'h20, 5'd9, 5'd1, 3'b101, 5'd0, 7'h13};
    b2b_ins[3] = {7'h00, 5'd17, 5'd1, 3'b001, 5'd0, 7'h13};
    for (int i = 0; i < 4; i++) begin
      b2b_rs1[i] = $urandom;
      b2b_rs2[i] = $urandom;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(b2b_ins[idx], b2b_rs1[idx], b2b_rs2[idx], 5'(idx + 1));
      tick(fin);
      if (fin) idx++;
    end
    chk("b2b_stalled_accepts", idx, 2);
    chk("b2b_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) drive(b2b_ins[idx], b2b_rs1[idx], b2b_rs2[idx], 5'(idx + 1));
      else in_valid = 1'b0;
      tick(fin);
      if (fin) idx++;
    end
    chk("b2b_all_accepted", idx, 4);
    chk("b2b_drained", q.size(), 0);

    // Reset with main and skid both full
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(rand_instr(), $urandom, $urandom, 5'($urandom));
      tick(fin);
    end
    in_valid = 1'b0;
    chk("pre_rst_full", q.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_wdata", out_wdata, 32'd0);
    q.delete();
    exp_perf = 32'd0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick(fin);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      in_rd     = 5'($urandom);
      tick(fin);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick(fin);

`ifdef SHIFT_PERF_CNT_EN
    // Counter wraps from all-ones to zero
    force dut.r_perf_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_cnt;
    exp_perf = 32'hFFFF_FFFF;
    drive({7'h00, 5'd1, 5'd1, 3'b001, 5'd3, 7'h13}, 32'd1, 32'd0, 5'd3);
    tick(fin);
    in_valid = 1'b0;
    repeat (2) tick(fin);
    chk("perf_wrap", perf_shift_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_shift_stage.md
Name: ex_shift_stage

Overview:
- Execute-stage shift pipeline slot. Accepts decoded RV32I shift instructions from ID over a valid/ready handshake.
- Decodes the shift opcode and drives operands to the combinational shifter (A, B, Shiftop).
- Registers the shifter result into a 2-entry output buffer (main + skid) feeding WB over valid/ready.
- Sits directly upstream and downstream of the shifter: it produces the shifter's inputs and consumes its Result.

Parameters:
- DATA_WIDTH, 32, operand/result width; shift amount is always the low 5 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ID holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  raw instruction word
- in_rs1  input  32  rs1 value
- in_rs2  input  32  rs2 value
- in_rd  input  5  destination register index
- sh_A  output  32  shifter operand A (= in_rs1)
- sh_B  output  32  shifter operand B (rs2 value or zero-extended shamt)
- sh_op  output  2  shifter Shiftop: 00 SLL, 01 SRL, 11 SRA
- sh_result  input  32  shifter Result, combinational from sh_A/sh_B/sh_op
- out_valid  output  1  WB entry valid
- out_ready  input  1  WB accepts
- out_rd  output  5  destination index
- out_wdata  output  32  shift result, 0 if illegal
- out_we  output  1  register write enable
- out_illegal  output  1  instruction not a legal shift

Behaviour:
- Reset (async, rst_n=0): main_valid=0, skid_valid=0, out_valid=0, out_rd=0, out_wdata=0, out_we=0, out_illegal=0, in_ready=1. Reset mid-transfer drops both entries; no output fires after release until a new accept.
- Decode (combinational on in_instr):
  - opcode 0110011, funct3 001, funct7 0000000 -> SLL, B=in_rs2.
  - opcode 0110011, funct3 101, funct7 0000000 -> SRL, B=in_rs2.
  - opcode 0110011, funct3 101, funct7 0100000 -> SRA, B=in_rs2.
  - opcode 0010011, funct3 001, instr[31:25]=0000000 -> SLLI, B={27'b0, instr[24:20]}.
  - opcode 0010011, funct3 101, instr[31:25]=0000000 -> SRLI.
  - opcode 0010011, funct3 101, instr[31:25]=0100000 -> SRAI.
  - Anything else is illegal: sh_op=00 and B=0 driven, result forced to 0. This includes instr[25]=1 on immediate forms.
  - sh_A=in_rs1 always. sh_B upper bits are passed through; the shifter uses only B[4:0].
- Accept: fire_in = in_valid & in_ready. sh_result is sampled in the same cycle as fire_in. Latency 1 cycle, accept edge to out_valid.
- Captured entry: {rd, wdata, we, illegal}.
  - we = legal & (rd != 0).
  - wdata = sh_result if legal, else 0.
- in_ready = !skid_valid. It is a registered term with no combinational path from out_ready.
- Buffer rules, per cycle, with fire_out = out_valid & out_ready:
  - main empty & fire_in: entry -> main.
  - main full & fire_out & fire_in: entry -> main.
  - main full & !fire_out & fire_in: entry -> skid; in_ready drops the next cycle.
  - skid full & fire_out: skid -> main, skid clears, in_ready=1 the next cycle.
- Outputs come from the main entry; out_valid = main_valid.
- Main entry fields hold stable while out_valid & !out_ready.
- Full throughput: one instruction per cycle when out_ready=1 continuously.
- Order is preserved strictly FIFO. No entry is duplicated or dropped.

Optional Feature:
- Macro SHIFT_PERF_CNT_EN.
- Defined: adds output perf_shift_cnt[31:0].
  - Increments by 1 on each fire_out with out_illegal=0.
  - Wraps from 0xFFFFFFFF to 0.
  - Resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, in_valid=0 -> out_valid=0, in_ready=1, all outputs 0.
- SRA rs1=0x80000010, rs2=0x00000024 (shamt 4), rd=5, out_ready=1 -> next cycle out_valid=1, out_wdata=0xF8000001, out_we=1, out_illegal=0.
- SLLI shamt=31 rd=0 rs1=0x1 -> wdata=0x80000000, out_we=0. SRLI with instr[25]=1 -> out_illegal=1, wdata=0, we=0.
- Back-to-back 4 instructions, out_ready=0 from cycle 1:
  - 2 instructions captured, then in_ready=0.
  - Raise out_ready: results emerge in order, with in_ready returning the cycle after skid drains.
- Assert rst_n=0 while main and skid full -> out_valid=0 and in_ready=1 immediately. After release, no stale entries are emitted.
- With SHIFT_PERF_CNT_EN: 3 legal + 1 illegal retired -> perf_shift_cnt=3. Preload via force at 0xFFFFFFFF, one more legal -> 0.
